grava_embarcacoes: RTL and testbench

GRAVA_EMBARCACOES -- requirements
Module: grava_embarcacoes

---
 rtl/grava_embarcacoes.sv | 150 +++++++++++++++
 tb/tb_grava_embarcacoes.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/grava_embarcacoes.sv
// Writes one player's fleet (NUM_EMBARCACOES ship records) into memory A or B via a valid/ready handshake.
// Optional macro GRAVA_LIMPEZA_EN clears the selected memory to zero before the records are written.
module grava_embarcacoes #(
    parameter int NUM_EMBARCACOES = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        jogador,
    input  logic        dado_valido,
    input  logic [63:0] posicoesEmbarcacao,
    output logic        dado_pronto,
    output logic [4:0]  endereco,
    output logic [63:0] dados,
    output logic        wrenA,
    output logic        wrenB,
    output logic [3:0]  embarcacao_atual,
    output logic        ocupado,
    output logic        concluido
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LIMPA  = 3'd1,
        ESPERA = 3'd2,
        GRAVA  = 3'd3,
        FIM    = 3'd4
    } estado_t;

    localparam logic [4:0] ULTIMO = 5'(NUM_EMBARCACOES - 1);

    estado_t     estado_r, estado_s;
    logic        jogador_r, jogador_s;
    logic [4:0]  endereco_r, endereco_s;
    logic [63:0] dados_r, dados_s;

    logic        dado_pronto_r, dado_pronto_s;
    logic        wrena_r, wrena_s;
    logic        wrenb_r, wrenb_s;
    logic [3:0]  embarcacao_r, embarcacao_s;
    logic        ocupado_r, ocupado_s;
    logic        concluido_r, concluido_s;

    // Next-state, address and data-path decisions
    always_comb begin
        estado_s   = estado_r;
        jogador_s  = jogador_r;
        endereco_s = endereco_r;
        dados_s    = dados_r;
        case (estado_r)
            IDLE, FIM: begin
                if (iniciar) begin
                    jogador_s  = jogador;
                    endereco_s = 5'd0;
`ifdef GRAVA_LIMPEZA_EN
                    dados_s    = 64'd0;
                    estado_s   = LIMPA;
`else
                    estado_s   = ESPERA;
`endif
                end else begin
                    estado_s = estado_r;
                end
            end
            LIMPA: begin
`ifdef GRAVA_LIMPEZA_EN
                if (endereco_r == ULTIMO) begin
                    endereco_s = 5'd0;
                    estado_s   = ESPERA;
                end else begin
                    endereco_s = endereco_r + 5'd1;
                end
`else
                estado_s = IDLE;
`endif
            end
            ESPERA: begin
                // dado_pronto is high exactly in ESPERA, so dado_valido alone completes the handshake
                if (dado_valido) begin
                    dados_s  = posicoesEmbarcacao;
                    estado_s = GRAVA;
                end else begin
                    estado_s = ESPERA;
                end
            end
            GRAVA: begin
                if (endereco_r == ULTIMO) begin
                    estado_s = FIM;
                end else begin
                    endereco_s = endereco_r + 5'd1;
                    estado_s   = ESPERA;
                end
            end
            default: begin
                estado_s = IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so they can be registered alongside it
    always_comb begin
        dado_pronto_s = (estado_s == ESPERA);
        wrena_s       = ((estado_s == GRAVA) || (estado_s == LIMPA)) && jogador_s;
        wrenb_s       = ((estado_s == GRAVA) || (estado_s == LIMPA)) && !jogador_s;
        ocupado_s     = (estado_s == LIMPA) || (estado_s == ESPERA) || (estado_s == GRAVA);
        concluido_s   = (estado_s == FIM);
        if ((estado_s == ESPERA) || (estado_s == GRAVA)) begin
            embarcacao_s = 4'(endereco_s + 5'd1);
        end else begin
            embarcacao_s = 4'd0;
        end
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r      <= IDLE;
            jogador_r     <= 1'b0;
            endereco_r    <= 5'd0;
            dados_r       <= 64'd0;
            dado_pronto_r <= 1'b0;
            wrena_r       <= 1'b0;
            wrenb_r       <= 1'b0;
            embarcacao_r  <= 4'd0;
            ocupado_r     <= 1'b0;
            concluido_r   <= 1'b0;
        end else begin
            estado_r      <= estado_s;
            jogador_r     <= jogador_s;
            endereco_r    <= endereco_s;
            dados_r       <= dados_s;
            dado_pronto_r <= dado_pronto_s;
            wrena_r       <= wrena_s;
            wrenb_r       <= wrenb_s;
            embarcacao_r  <= embarcacao_s;
            ocupado_r     <= ocupado_s;
            concluido_r   <= concluido_s;
        end
    end

    assign dado_pronto      = dado_pronto_r;
    assign endereco         = endereco_r;
    assign dados            = dados_r;
    assign wrenA            = wrena_r;
    assign wrenB            = wrenb_r;
    assign embarcacao_atual = embarcacao_r;
    assign ocupado          = ocupado_r;
    assign concluido        = concluido_r;

endmodule

// File: tb/tb_grava_embarcacoes.sv
// Self-checking bench for grava_embarcacoes: directed scenarios then random traffic against a transaction model.
// Follows GRAVA_LIMPEZA_EN when the macro is defined for the build.
module tb_grava_embarcacoes;

    localparam int N = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iniciar = 1'b0;
    logic        jogador = 1'b0;
    logic        dado_valido = 1'b0;
    logic [63:0] posicoesEmbarcacao = 64'd0;
    logic        dado_pronto;
    logic [4:0]  endereco;
    logic [63:0] dados;
    logic        wrenA;
    logic        wrenB;
    logic [3:0]  embarcacao_atual;
    logic        ocupado;
    logic        concluido;

    int total = 0;
    int bad = 0;

    // Model: a fleet run, its optional clear pass, a pending write, and the last data/address
    bit          m_run = 1'b0;
    bit          m_clr = 1'b0;
    bit          m_wr = 1'b0;
    bit          m_done = 1'b0;
    bit          m_sel = 1'b0;
    int          m_addr = 0;
    logic [63:0] m_data = 64'd0;

    grava_embarcacoes #(.NUM_EMBARCACOES(N)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .jogador(jogador),
        .dado_valido(dado_valido), .posicoesEmbarcacao(posicoesEmbarcacao),
        .dado_pronto(dado_pronto), .endereco(endereco), .dados(dados),
        .wrenA(wrenA), .wrenB(wrenB), .embarcacao_atual(embarcacao_atual),
        .ocupado(ocupado), .concluido(concluido)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_pronto();
        return m_run && !m_clr && !m_wr;
    endfunction

    // One clock: apply inputs, advance the model on the edge, compare every output afterwards
    task automatic cyc(input bit r, input bit ini, input bit jog, input bit dv, input logic [63:0] d);
        bit hs;
        reset = r; iniciar = ini; jogador = jog; dado_valido = dv; posicoesEmbarcacao = d;
        hs = dv && exp_pronto();
        @(posedge clk);
        if (r) begin
            m_run = 1'b0; m_clr = 1'b0; m_wr = 1'b0; m_done = 1'b0;
            m_sel = 1'b0; m_addr = 0; m_data = 64'd0;
        end else if (!m_run) begin
            if (ini) begin
                m_run = 1'b1; m_sel = jog; m_addr = 0; m_done = 1'b0;
`ifdef GRAVA_LIMPEZA_EN
                m_clr = 1'b1; m_data = 64'd0;
`endif
            end
        end else if (m_clr) begin
            if (m_addr == N - 1) begin m_addr = 0; m_clr = 1'b0; end
            else m_addr++;
        end else if (m_wr) begin
            m_wr = 1'b0;
            if (m_addr == N - 1) begin m_run = 1'b0; m_done = 1'b1; end
            else m_addr++;
        end else if (hs) begin
            m_data = d; m_wr = 1'b1;
        end
        #1;
        chk("dado_pronto", 64'(dado_pronto), 64'(exp_pronto()));
        chk("endereco", 64'(endereco), 64'(m_addr));
        chk("dados", dados, m_data);
        chk("wrenA", 64'(wrenA), 64'((m_wr || m_clr) && m_sel));
        chk("wrenB", 64'(wrenB), 64'((m_wr || m_clr) && !m_sel));
        chk("embarcacao_atual", 64'(embarcacao_atual), (m_run && !m_clr) ? 64'(m_addr + 1) : 64'd0);
        chk("ocupado", 64'(ocupado), 64'(m_run));
        chk("concluido", 64'(concluido), 64'(m_done));
    endtask

    // Idle for dly cycles, then hold dado_valido until the record is accepted (bounded)
    task automatic hs(input bit jog, input logic [63:0] d, input int dly);
        int g;
        repeat (dly) cyc(1'b0, 1'b0, jog, 1'b0, 64'd0);
        g = 0;
        while (!m_wr && g < 60) begin
            cyc(1'b0, 1'b0, jog, 1'b1, d);
            g++;
        end
        if (!m_wr) chk("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input bit jog, input logic [63:0] d, input int dly, input bit hold);
        hs(jog, d, dly);
        cyc(1'b0, 1'b0, jog, hold, d);
    endtask

    initial begin
        // Reset held for two cycles, then released
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

        // Fleet into memory A, records 1..11 with dado_valido held high
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        for (int k = 1; k <= N; k++) send(1'b1, 64'(k), 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

        // Fleet into memory B with a three-cycle gap before each record
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        for (int k = 0; k < N; k++) send(1'b0, {$urandom, $urandom}, 3, 1'b0);

        // Restart attempt and jogador change while waiting at address 4
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        for (int k = 0; k < 4; k++) send(1'b1, {$urandom, $urandom}, 1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        for (int k = 4; k < N; k++) send(1'b0, {$urandom, $urandom}, 0, 1'b0);

        // Reset during the write at address 6, then a fresh start
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        for (int k = 0; k < 6; k++) send(1'b0, {$urandom, $urandom}, 0, 1'b0);
        hs(1'b0, 64'hDEAD_BEEF_0000_0006, 0);
        chk("addr_at_abort", 64'(endereco), 64'd6);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h77);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        for (int k = 0; k < 2; k++) send(1'b1, {$urandom, $urandom}, 0, 1'b0);

        // Random traffic including occasional resets and restarts
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) != 0, {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
